// File: rtl/wb_xbar_ctrl.sv
// Single-master Wishbone crossbar controller: decodes the top address nibble to one of NS
// slaves, runs one transaction at a time and terminates it with ack, err (miss/timeout) or abort.
module wb_xbar_ctrl #(
    parameter int DW  = 32,
    parameter int AW  = 32,
    parameter int NS  = 8,
    parameter int TMO = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m_cyc_i,
    input  logic                m_stb_i,
    input  logic                m_we_i,
    input  logic [AW-1:0]       m_adr_i,
    input  logic [DW/8-1:0]     m_sel_i,
    input  logic [DW-1:0]       m_dat_i,
    output logic [DW-1:0]       m_dat_o,
    output logic                m_ack_o,
    output logic                m_err_o,
    output logic [NS-1:0]       s_cyc_o,
    output logic [NS-1:0]       s_stb_o,
    output logic                s_we_o,
    output logic [AW-1:0]       s_adr_o,
    output logic [DW/8-1:0]     s_sel_o,
    output logic [DW-1:0]       s_dat_o,
    input  logic [NS*DW-1:0]    s_dat_i,
    input  logic [NS-1:0]       s_ack_i
);

    localparam int CW = (TMO > 0) ? $clog2(TMO + 1) : 1;
    localparam logic [CW-1:0] TMO_C = CW'(TMO);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_ERR} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [AW-1:0]      r_adr;
    logic               r_we;
    logic [DW/8-1:0]    r_sel;
    logic [DW-1:0]      r_dat;
    logic [DW-1:0]      r_rdata;
    logic [3:0]         r_idx;
    logic [CW-1:0]      r_cnt;

    logic [3:0]         w_req_idx;
    logic               w_hit;
    logic               w_req;
    logic [NS-1:0]      w_sel_oh;
    logic [DW-1:0]      w_sdat [NS];
    logic [DW-1:0]      w_rdata;
    logic               w_ack;
    logic               w_timeout;

    assign w_req_idx = m_adr_i[AW-1:AW-4];
    assign w_hit     = ({1'b0, w_req_idx} < 5'(NS));
    assign w_req     = m_cyc_i && m_stb_i;

    // A latched miss index matches no slave, so the one-hot select is all zero on ERR.
    generate
        for (genvar gi = 0; gi < NS; gi++) begin : g_slave
            assign w_sel_oh[gi] = (r_idx == 4'(gi));
            assign w_sdat[gi]   = s_dat_i[gi*DW +: DW];
        end
    endgenerate

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NS; i++) begin
            if (w_sel_oh[i]) begin
                w_rdata = w_rdata | w_sdat[i];
            end
        end
    end

    assign w_ack     = |(s_ack_i & w_sel_oh);
    assign w_timeout = (TMO != 0) && (r_cnt == TMO_C);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Abort outranks ack, which outranks timeout.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_state_next = w_hit ? S_REQ : S_ERR;
                end
            end
            S_REQ: begin
                if (!m_cyc_i) begin
                    w_state_next = S_IDLE;
                end else if (w_ack) begin
                    w_state_next = S_RESP;
                end else if (w_timeout) begin
                    w_state_next = S_ERR;
                end
            end
            S_RESP:  w_state_next = S_IDLE;
            S_ERR:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_adr   <= '0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_dat   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
        end else begin
            if (r_state == S_IDLE && w_req) begin
                r_adr <= m_adr_i;
                r_we  <= m_we_i;
                r_sel <= m_sel_i;
                r_dat <= m_dat_i;
                r_idx <= w_req_idx;
                r_cnt <= '0;
            end else if (r_state == S_REQ && r_cnt != TMO_C) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (r_state == S_REQ && m_cyc_i && w_ack && !r_we) begin
                r_rdata <= w_rdata;
            end
        end
    end

    assign s_cyc_o = (r_state == S_REQ) ? w_sel_oh : '0;
    assign s_stb_o = (r_state == S_REQ) ? w_sel_oh : '0;
    assign s_we_o  = r_we;
    assign s_adr_o = r_adr;
    assign s_sel_o = r_sel;
    assign s_dat_o = r_dat;
    assign m_dat_o = r_rdata;
    assign m_ack_o = (r_state == S_RESP);
    assign m_err_o = (r_state == S_ERR);

endmodule

// File: tb/tb_wb_xbar_ctrl.sv
// Directed and randomized transactions against a cycle-count model of the controller's
// termination rules (decode, ack latency, timeout, abort, reset).
module tb_wb_xbar_ctrl;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int NS  = 8;
    localparam int TMO = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               m_cyc_i = 1'b0, m_stb_i = 1'b0, m_we_i = 1'b0;
    logic [AW-1:0]      m_adr_i = '0;
    logic [DW/8-1:0]    m_sel_i = '0;
    logic [DW-1:0]      m_dat_i = '0;
    logic [DW-1:0]      m_dat_o;
    logic               m_ack_o, m_err_o;
    logic [NS-1:0]      s_cyc_o, s_stb_o;
    logic               s_we_o;
    logic [AW-1:0]      s_adr_o;
    logic [DW/8-1:0]    s_sel_o;
    logic [DW-1:0]      s_dat_o;
    logic [NS*DW-1:0]   s_dat_i = '0;
    logic [NS-1:0]      s_ack_i = '0;

    int                 n_tests = 0;
    int                 n_fail  = 0;
    logic [DW-1:0]      exp_dat = '0;

    wb_xbar_ctrl #(.DW(DW), .AW(AW), .NS(NS), .TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_sel_i(m_sel_i), .m_dat_i(m_dat_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".stb"}, 64'(s_stb_o), 64'(0));
        chk({tag, ".cyc"}, 64'(s_cyc_o), 64'(0));
        chk({tag, ".ack"}, 64'(m_ack_o), 64'(0));
        chk({tag, ".err"}, 64'(m_err_o), 64'(0));
        chk({tag, ".dat"}, 64'(m_dat_o), 64'(exp_dat));
    endtask

    task automatic rand_slaves();
        for (int i = 0; i < NS; i++) s_dat_i[i*DW +: DW] = $urandom;
    endtask

    // One transaction; n = slave ack delay in cycles after the strobe rises (n > TMO: never acks).
    task automatic txn(input logic [AW-1:0] adr, input logic we, input logic [3:0] sel,
                       input logic [DW-1:0] dat, input int n, input logic [DW-1:0] rd);
        int            idx, last;
        bit            hit, acked;
        logic [NS-1:0] oh;
        idx   = int'(adr[AW-1:AW-4]);
        hit   = idx < NS;
        acked = n <= TMO;
        last  = 1 + (acked ? n : TMO);
        oh    = hit ? (NS'(1) << idx) : '0;
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = we;
        m_adr_i = adr; m_sel_i = sel; m_dat_i = dat; s_ack_i = '0;
        tick();
        if (!hit) begin
            chk("miss.err", 64'(m_err_o), 64'(1));
            chk("miss.ack", 64'(m_ack_o), 64'(0));
            chk("miss.stb", 64'(s_stb_o), 64'(0));
            m_cyc_i = 1'b0; m_stb_i = 1'b0;
            s_ack_i = NS'($urandom);
            tick();
            chk_quiet("miss.after");
            s_ack_i = '0;
            $display("[TB] miss adr=%08h err issued", adr);
            return;
        end
        for (int c = 1; c <= last; c++) begin
            chk("req.stb", 64'(s_stb_o), 64'(oh));
            chk("req.cyc", 64'(s_cyc_o), 64'(oh));
            chk("req.ack", 64'(m_ack_o), 64'(0));
            chk("req.err", 64'(m_err_o), 64'(0));
            if (c == 1) begin
                chk("req.we",  64'(s_we_o),  64'(we));
                chk("req.adr", 64'(s_adr_o), 64'(adr));
                chk("req.sel", 64'(s_sel_o), 64'(sel));
                chk("req.dat", 64'(s_dat_o), 64'(dat));
            end
            rand_slaves();
            s_dat_i[idx*DW +: DW] = rd;
            s_ack_i = NS'($urandom) & ~oh;
            if (acked && c == 1 + n) s_ack_i = s_ack_i | oh;
            tick();
        end
        if (acked && !we) exp_dat = rd;
        chk("end.stb", 64'(s_stb_o), 64'(0));
        chk("end.ack", 64'(m_ack_o), 64'(acked));
        chk("end.err", 64'(m_err_o), 64'(!acked));
        chk("end.dat", 64'(m_dat_o), 64'(exp_dat));
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        s_ack_i = NS'($urandom);
        tick();
        chk_quiet("end.idle");
        s_ack_i = '0;
        $display("[TB] %s slave=%0d adr=%08h delay=%0d -> %s dat=%08h",
                 we ? "write" : "read", idx, adr, n, acked ? "ack" : "timeout", m_dat_o);
    endtask

    // Master drops m_cyc_i in cycle 1+a of REQ while the slave acks in that same cycle.
    task automatic txn_abort(input logic [AW-1:0] adr, input int a);
        int            idx;
        logic [NS-1:0] oh;
        idx = int'(adr[AW-1:AW-4]);
        oh  = NS'(1) << idx;
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b0; m_adr_i = adr;
        tick();
        for (int c = 1; c <= 1 + a; c++) begin
            chk("abort.stb", 64'(s_stb_o), 64'(oh));
            rand_slaves();
            if (c == 1 + a) begin
                s_ack_i = oh;
                m_cyc_i = 1'b0; m_stb_i = 1'b0;
            end
            tick();
        end
        s_ack_i = '0;
        chk_quiet("abort.next");
        tick();
        chk_quiet("abort.idle");
        $display("[TB] abort slave=%0d after %0d cycles, no termination", idx, a + 1);
    endtask

    initial begin
        rst = 1'b0;
        tick();
        tick();
        chk_quiet("reset");
        $display("[TB] reset state checked");
        rst = 1'b1;
        tick();

        txn(32'h2000_0010, 1'b0, 4'hF, 32'h0, 1, 32'hDEAD_BEEF);
        txn(32'h0000_0004, 1'b1, 4'hF, 32'h1234_5678, 0, 32'hCAFE_F00D);
        txn(32'h9000_0000, 1'b0, 4'hF, 32'h0, 0, 32'h0);
        txn(32'h5000_0000, 1'b0, 4'h3, 32'h0, 100, 32'h1111_1111);
        txn(32'h7000_0008, 1'b0, 4'hF, 32'h0, TMO, 32'hA5A5_5A5A);
        txn_abort(32'h3000_0000, 2);
        txn_abort(32'h1000_0000, 0);

        // Reset mid-REQ, then a stray ack from slave 3 while idle.
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b0; m_adr_i = 32'h2000_0000;
        tick();
        chk("rstreq.stb", 64'(s_stb_o), 64'(8'h04));
        rst = 1'b0;
        tick();
        exp_dat = '0;
        chk_quiet("rstreq.after");
        rst = 1'b1; m_cyc_i = 1'b0; m_stb_i = 1'b0;
        s_ack_i = 8'h08;
        tick();
        chk_quiet("stray.ack");
        s_ack_i = '0;
        tick();
        chk_quiet("stray.idle");
        $display("[TB] reset in REQ and stray ack checked");

        for (int t = 0; t < 40; t++) begin
            logic [AW-1:0] adr;
            adr = {4'($urandom_range(0, 9)), 28'($urandom)};
            if (adr[AW-1:AW-4] < NS && $urandom_range(0, 5) == 0)
                txn_abort(adr, int'($urandom_range(0, TMO - 1)));
            else
                txn(adr, 1'($urandom), 4'($urandom), $urandom,
                    int'($urandom_range(0, TMO + 1)), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_xbar_ctrl.md
WB_XBAR_CTRL -- requirements
Module: wb_xbar_ctrl

Interface
REQ-001 Parameter DW, default 32: data width in bits, a multiple of 8.
REQ-002 Parameter AW, default 32: address width.
REQ-003 Parameter NS, default 8, range 1..16: number of slave ports.
REQ-004 Parameter TMO, default 255: REQ-state cycle limit before timeout; 0 disables the timeout.
REQ-005 clk  in  1  single clock; all flops on the rising edge.
REQ-006 rst  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-007 m_cyc_i, m_stb_i, m_we_i  in  1 each  master cycle, strobe, write enable.
REQ-008 m_adr_i  in  AW  address; m_sel_i  in  DW/8  byte lanes; m_dat_i  in  DW  write data.
REQ-009 m_dat_o  out  DW  read data; m_ack_o  out  1  completion; m_err_o  out  1  error termination.
REQ-010 s_cyc_o, s_stb_o  out  NS  one bit per slave.
REQ-011 s_we_o  out  1; s_adr_o  out  AW; s_sel_o  out  DW/8; s_dat_o  out  DW; all broadcast to every slave.
REQ-012 s_dat_i  in  NS*DW  slave read data, slave i at bits [i*DW +: DW].
REQ-013 s_ack_i  in  NS  per-slave acknowledge.

Function
REQ-014 Decode: slave index = m_adr_i[AW-1:AW-4]; an index >= NS is a decode miss.
REQ-015 FSM states: IDLE, REQ, RESP, ERR; reset state is IDLE.
REQ-016 IDLE: on m_cyc_i & m_stb_i, register adr/we/sel/dat and the index; on a hit go to REQ, on a miss go to ERR.
REQ-017 REQ: drive s_cyc_o[idx] and s_stb_o[idx] high and all other bits low; the s_* broadcast outputs hold the registered values.
REQ-018 REQ, s_ack_i[idx]=1: capture s_dat_i[idx] into m_dat_o if the access is a read, deassert the strobe next cycle, go to RESP.
REQ-019 REQ, no ack and the cycle counter equals TMO (TMO>0): drop the strobe and go to ERR.
REQ-020 REQ, m_cyc_i=0 (master abort): drop the strobe, go to IDLE, assert neither ack nor err; abort outranks an ack arriving in the same cycle.
REQ-021 RESP: m_ack_o=1 for exactly one cycle, then go to IDLE.
REQ-022 ERR: m_err_o=1 for exactly one cycle, then go to IDLE; m_ack_o and m_err_o are never high together.
REQ-023 s_ack_i from a non-selected slave, or any s_ack_i outside REQ, is ignored.
REQ-024 Latency: request sampled at edge k; s_stb_o high during cycle k+1; with the slave acking in cycle k+1+n, m_ack_o is high in cycle k+2+n.
REQ-025 Decode miss: m_err_o is high in cycle k+1; no s_stb_o bit asserts.
REQ-026 The timeout counter clears on entry to REQ and saturates at TMO; its width is clog2(TMO+1), with a minimum of 1.
REQ-027 m_dat_o holds the last completed read data; writes, errors and aborts leave it unchanged.
REQ-028 IDLE does not re-sample a request in the same cycle that RESP or ERR exits.

Reset
REQ-029 Reset takes effect at the next rising edge and overrides all state, including mid-transaction.
REQ-030 Reset values: state IDLE; s_cyc_o, s_stb_o, m_ack_o, m_err_o all 0; m_dat_o 0; counter 0; latched request 0.
REQ-031 Reset asserted while in REQ: the strobe drops the following cycle; no ack or err is issued for that transaction.

Verification
REQ-032 Read slave 2, adr 0x2000_0010, slave acks 1 cycle after stb with 0xDEADBEEF -> s_stb_o=0x04; m_ack_o pulses once; m_dat_o=0xDEADBEEF.
REQ-033 Write slave 0, dat 0x1234_5678, sel 0xF -> s_dat_o=0x12345678, s_we_o=1, s_sel_o=0xF; m_ack_o pulses; m_dat_o unchanged.
REQ-034 Access adr 0x9000_0000 with NS=8 -> m_err_o=1 in cycle k+1; s_stb_o stays 0; no m_ack_o.
REQ-035 TMO=4, slave never acks -> strobe high for 5 cycles, then m_err_o pulses; the next request proceeds normally.
REQ-036 Master drops m_cyc_i in REQ while the slave acks in the same cycle -> no ack or err; FSM returns to IDLE; m_dat_o unchanged.
REQ-037 Reset pulsed in REQ, then a stray ack from slave 3 while in IDLE -> all outputs 0; the stray ack is ignored.
